// File: rtl/enemy_wave_scheduler.sv
// Enemy wave scheduler: walks the active level's spawn queue ROM, waits for each
// entry's timestamp against a frame-driven game timer, picks the lowest free
// enemy slot and hands the spawn to the engine over a valid/ready handshake.
module enemy_wave_scheduler #(
   parameter int QUEUE_DEPTH = 64,
   parameter int ADDR_W      = 6,
   parameter int SLOT_CNT    = 8,
   parameter int TS_W        = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick,
   input  logic                level_start,
   input  logic [1:0]          level,
   input  logic                pause,
   input  logic [SLOT_CNT-1:0] slot_exist,
   output logic                q_rd_en,
   output logic [ADDR_W+1:0]   q_addr,
   input  logic [TS_W+2:0]     q_data,
   output logic                spawn_valid,
   output logic [2:0]          spawn_slot,
   output logic [2:0]          spawn_type,
   input  logic                spawn_ready,
   output logic [TS_W-1:0]     game_time,
   output logic [ADDR_W:0]     spawned_cnt,
   output logic                queue_done,
   output logic                busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_WAIT_DATA = 3'd2;
   localparam logic [2:0] S_WAIT_TIME = 3'd3;
   localparam logic [2:0] S_FIND_SLOT = 3'd4;
   localparam logic [2:0] S_SPAWN     = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   localparam logic [TS_W-1:0]   TS_MAX   = '1;
   localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(QUEUE_DEPTH);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(QUEUE_DEPTH - 1);

   logic [2:0]        state;
   logic [1:0]        bank;
   logic [ADDR_W-1:0] index;
   logic [TS_W-1:0]   entry_ts;
   logic [2:0]        entry_type;
   logic              free_found;
   logic [2:0]        free_idx;
   logic              start_ok;

   // level 0 is not a playable level, so its start pulse is dropped
   assign start_ok    = level_start && (level != 2'd0);

   assign q_rd_en     = (state == S_FETCH);
   assign q_addr      = {bank, index};
   assign spawn_valid = (state == S_SPAWN);
   assign queue_done  = (state == S_DONE);
   assign busy        = (state != S_IDLE) && (state != S_DONE);

   // lowest-index free slot; scan downward so the lowest zero wins
   always_comb begin
      free_found = 1'b0;
      free_idx   = 3'd0;
      for (int i = SLOT_CNT-1; i >= 0; i--) begin
         if (!slot_exist[i]) begin
            free_found = 1'b1;
            free_idx   = 3'(i);
         end
      end
   end

   // queue walk / spawn handshake state machine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         bank        <= 2'd0;
         index       <= '0;
         entry_ts    <= '0;
         entry_type  <= 3'd0;
         spawn_slot  <= 3'd0;
         spawn_type  <= 3'd0;
         spawned_cnt <= '0;
      end else if (start_ok) begin
         // restart wins over everything, including a pending request
         bank        <= level - 2'd1;
         index       <= '0;
         spawned_cnt <= '0;
         state       <= S_FETCH;
      end else begin
         case (state)
            S_FETCH: state <= S_WAIT_DATA;
            S_WAIT_DATA: begin
               entry_ts   <= q_data[TS_W+2:3];
               entry_type <= q_data[2:0];
               state      <= S_WAIT_TIME;
            end
            S_WAIT_TIME: begin
               if (entry_type == 3'd0)
                  state <= S_DONE;
               else if ((game_time >= entry_ts) && !pause)
                  state <= S_FIND_SLOT;
            end
            S_FIND_SLOT: begin
               // a full slot table stalls the queue rather than dropping entries
               if (!pause && free_found) begin
                  spawn_slot <= free_idx;
                  spawn_type <= entry_type;
                  state      <= S_SPAWN;
               end
            end
            S_SPAWN: begin
               if (spawn_ready) begin
                  if (spawned_cnt != CNT_MAX)
                     spawned_cnt <= spawned_cnt + 1'b1;
                  if (index == IDX_LAST) begin
                     state <= S_DONE;
                  end else begin
                     index <= index + 1'b1;
                     state <= S_FETCH;
                  end
               end
            end
            S_IDLE, S_DONE: state <= state;
            default: state <= S_IDLE;
         endcase
      end
   end

   // game timer: counts unpaused frames once a level is running, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         game_time <= '0;
      else if (start_ok)
         game_time <= '0;
      else if (frame_tick && !pause && (state != S_IDLE) && (game_time != TS_MAX))
         game_time <= game_time + 1'b1;
   end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Bench for enemy_wave_scheduler: directed scenarios plus randomized levels
// scored against a transaction-level model of the spawn sequence and timer.
module tb_enemy_wave_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        level_start = 1'b0;
   logic [1:0]  level = 2'd0;
   logic        pause = 1'b0;
   logic [7:0]  slot_exist = 8'h00;
   logic        q_rd_en;
   logic [7:0]  q_addr;
   logic [14:0] q_data = 15'd0;
   logic        spawn_valid;
   logic [2:0]  spawn_slot;
   logic [2:0]  spawn_type;
   logic        spawn_ready = 1'b0;
   logic [11:0] game_time;
   logic [6:0]  spawned_cnt;
   logic        queue_done;
   logic        busy;

   enemy_wave_scheduler dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .level_start(level_start),
      .level(level), .pause(pause), .slot_exist(slot_exist), .q_rd_en(q_rd_en),
      .q_addr(q_addr), .q_data(q_data), .spawn_valid(spawn_valid),
      .spawn_slot(spawn_slot), .spawn_type(spawn_type), .spawn_ready(spawn_ready),
      .game_time(game_time), .spawned_cnt(spawned_cnt), .queue_done(queue_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // queue ROM model: registered read, data one cycle after the strobe
   logic [14:0] rom [0:255];
   always @(posedge clk) if (q_rd_en) q_data <= rom[q_addr];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int lowest_free(input logic [7:0] se);
      for (int i = 0; i < 8; i++) if (!se[i]) return i;
      return -1;
   endfunction

   // reference state for randomized levels
   bit          rnd = 1'b0;
   int          sb_idx = 0;
   int          rd_cnt = 0;
   logic [11:0] exp_ts [0:63];
   logic [2:0]  exp_ty [0:63];
   int          exp_slot = 0;
   int          model_gt = 0;
   bit          model_run = 1'b0;
   bit          pend = 1'b0;
   logic [2:0]  pend_slot, pend_ty;

   // monitor on the falling edge: inputs and outputs are both settled here
   always @(negedge clk) begin
      if (q_rd_en) rd_cnt++;
      if (rnd) begin
         chk("rnd_game_time", game_time, model_gt);
         if (pend) begin
            chk("rnd_hold_valid", spawn_valid, 1);
            chk("rnd_hold_slot", spawn_slot, pend_slot);
            chk("rnd_hold_type", spawn_type, pend_ty);
         end
         if (level_start) sb_idx = 0;
         else if (spawn_valid && spawn_ready && sb_idx < 64) begin
            chk("rnd_type", spawn_type, exp_ty[sb_idx]);
            chk("rnd_slot", spawn_slot, exp_slot);
            chk("rnd_due", (game_time >= exp_ts[sb_idx]) ? 1 : 0, 1);
            sb_idx++;
         end
         pend      = spawn_valid && !spawn_ready && !level_start && !rst;
         pend_slot = spawn_slot;
         pend_ty   = spawn_type;
      end
      if (rst) begin
         model_gt  = 0;
         model_run = 1'b0;
      end else if (level_start && level != 2'd0) begin
         model_gt  = 0;
         model_run = 1'b1;
      end else if (model_run && frame_tick && !pause && model_gt < 4095)
         model_gt++;
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_level(input logic [1:0] l);
      level = l; level_start = 1'b1;
      cyc(1);
      level_start = 1'b0;
   endtask

   task automatic set_ent(input int b, input int idx, input int ts, input int ty);
      rom[b*64 + idx] = {12'(ts), 3'(ty)};
   endtask

   task automatic wait_valid(input string tag, input int max);
      int c = 0;
      while (!spawn_valid && c < max) begin cyc(1); c++; end
      chk(tag, spawn_valid, 1);
   endtask

   task automatic wait_done(input string tag, input int max);
      int c = 0;
      while (!queue_done && c < max) begin cyc(1); c++; end
      chk(tag, queue_done, 1);
   endtask

   initial begin
      int base;
      bit seen, stable;
      for (int i = 0; i < 256; i++) rom[i] = 15'd0;

      // reset state
      cyc(3);
      chk("rst_rd_en", q_rd_en, 0);  chk("rst_addr", q_addr, 0);
      chk("rst_valid", spawn_valid, 0); chk("rst_slot", spawn_slot, 0);
      chk("rst_type", spawn_type, 0); chk("rst_time", game_time, 0);
      chk("rst_cnt", spawned_cnt, 0); chk("rst_done", queue_done, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      cyc(2);

      // first fetch address and a due entry spawning into slot 0
      set_ent(1, 0, 0, 3); set_ent(1, 1, 0, 0);
      slot_exist = 8'h00; spawn_ready = 1'b1;
      start_level(2'd2);
      chk("t1_rd_en", q_rd_en, 1);
      chk("t1_addr", q_addr, 8'h40);
      wait_valid("t1_valid", 8);
      chk("t1_slot", spawn_slot, 0); chk("t1_type", spawn_type, 3);
      cyc(1);
      chk("t1_cnt", spawned_cnt, 1); chk("t1_valid_drop", spawn_valid, 0);
      wait_done("t1_done", 10);
      chk("t1_busy", busy, 0);

      // timestamp 5 with ticks 2 and 3 paused: due only on the 7th tick
      set_ent(0, 0, 5, 2); set_ent(0, 1, 0, 0);
      spawn_ready = 1'b0;
      start_level(2'd1);
      for (int t = 1; t <= 7; t++) begin
         pause = (t == 2 || t == 3); frame_tick = 1'b1;
         cyc(1);
         frame_tick = 1'b0; pause = 1'b0;
         cyc(3);
         chk("t2_time", game_time, t - ((t >= 3) ? 2 : (t >= 2) ? 1 : 0));
         chk("t2_valid", spawn_valid, (t == 7) ? 1 : 0);
      end
      spawn_ready = 1'b1;
      cyc(1);
      chk("t2_cnt", spawned_cnt, 1);

      // all slots busy stalls; freeing slot 5 releases it, then slot 0
      set_ent(2, 0, 0, 4); set_ent(2, 1, 0, 5); set_ent(2, 2, 0, 0);
      slot_exist = 8'hFF;
      start_level(2'd3);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin cyc(1); seen |= spawn_valid; end
      chk("t3_full_stall", seen, 0);
      slot_exist = 8'hDF;
      seen = 1'b0;
      for (int i = 0; i < 2 && !seen; i++) begin cyc(1); seen = spawn_valid; end
      chk("t3_valid5", seen, 1);
      chk("t3_slot5", spawn_slot, 5); chk("t3_type4", spawn_type, 4);
      slot_exist = 8'h00;
      cyc(1);
      wait_valid("t3_valid0", 8);
      chk("t3_slot0", spawn_slot, 0); chk("t3_type5", spawn_type, 5);
      cyc(1);
      chk("t3_cnt", spawned_cnt, 2);

      // back-pressure: request held stable for 10 cycles, one count on accept
      set_ent(0, 0, 0, 6); set_ent(0, 1, 0, 0);
      slot_exist = 8'h03; spawn_ready = 1'b0;
      start_level(2'd1);
      wait_valid("t4_valid", 8);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (!spawn_valid || spawn_slot != 3'd2 || spawn_type != 3'd6 || spawned_cnt != 7'd0)
            stable = 1'b0;
      end
      chk("t4_stable", stable, 1);
      spawn_ready = 1'b1;
      cyc(1);
      chk("t4_cnt", spawned_cnt, 1); chk("t4_drop", spawn_valid, 0);

      // three entries then terminator
      set_ent(1, 0, 0, 1); set_ent(1, 1, 1, 2); set_ent(1, 2, 1, 7); set_ent(1, 3, 0, 0);
      slot_exist = 8'h00;
      start_level(2'd2);
      frame_tick = 1'b1;
      wait_done("t5_done", 200);
      frame_tick = 1'b0;
      chk("t5_cnt", spawned_cnt, 3); chk("t5_busy", busy, 0);
      base = rd_cnt;
      cyc(20);
      chk("t5_no_read", rd_cnt - base, 0);
      level = 2'd0; level_start = 1'b1; cyc(1); level_start = 1'b0;
      chk("t5_lvl0_ignored", queue_done, 1); chk("t5_lvl0_no_read", q_rd_en, 0);

      // full bank without terminator: 64 spawns, no wrap
      for (int i = 0; i < 64; i++) set_ent(0, i, 0, (i % 7) + 1);
      base = rd_cnt;
      start_level(2'd1);
      wait_done("t5b_done", 1000);
      chk("t5b_cnt", spawned_cnt, 64);
      chk("t5b_reads", rd_cnt - base, 64);
      cyc(20);
      chk("t5b_no_wrap", rd_cnt - base, 64);

      // restart during a pending spawn
      set_ent(2, 0, 0, 1); set_ent(2, 1, 2, 3); set_ent(2, 2, 0, 0);
      spawn_ready = 1'b1;
      start_level(2'd3);
      wait_valid("t6_valid1", 8);
      cyc(1);
      spawn_ready = 1'b0;
      chk("t6_cnt1", spawned_cnt, 1);
      frame_tick = 1'b1; cyc(3); frame_tick = 1'b0;
      wait_valid("t6_valid2", 8);
      chk("t6_time3", game_time, 3);
      set_ent(2, 0, 100, 1);
      start_level(2'd3);
      chk("t6_abort_valid", spawn_valid, 0); chk("t6_abort_cnt", spawned_cnt, 0);
      chk("t6_abort_time", game_time, 0); chk("t6_refetch", q_rd_en, 1);
      chk("t6_refetch_addr", q_addr, 8'h80);

      // async reset while waiting on a timestamp
      frame_tick = 1'b1; cyc(5); frame_tick = 1'b0;
      chk("t7_busy", busy, 1); chk("t7_time", game_time, 5);
      #2 rst = 1'b1;
      #1;
      chk("t7_rd_en", q_rd_en, 0); chk("t7_addr", q_addr, 0);
      chk("t7_valid", spawn_valid, 0); chk("t7_time0", game_time, 0);
      chk("t7_cnt", spawned_cnt, 0); chk("t7_done", queue_done, 0);
      chk("t7_busy0", busy, 0);
      @(posedge clk); #1 rst = 1'b0;
      cyc(2);

      // randomized levels against the reference model
      rnd = 1'b1;
      for (int it = 0; it < 6; it++) begin
         int lvl, n, t, c;
         logic [7:0] se;
         lvl = $urandom_range(1, 3);
         n   = $urandom_range(1, 10);
         t   = 0;
         for (int k = 0; k < n; k++) begin
            t += $urandom_range(0, 3);
            exp_ts[k] = 12'(t);
            exp_ty[k] = 3'($urandom_range(1, 7));
            set_ent(lvl - 1, k, t, exp_ty[k]);
         end
         set_ent(lvl - 1, n, 0, 0);
         se = 8'($urandom);
         if (se == 8'hFF) se = 8'h7F;
         slot_exist = se;
         exp_slot   = lowest_free(se);
         start_level(2'(lvl));
         c = 0;
         while (!(queue_done && sb_idx == n) && c < 3000) begin
            frame_tick  = ($urandom % 2) == 0;
            pause       = ($urandom % 7) == 0;
            spawn_ready = ($urandom % 3) != 0;
            cyc(1);
            c++;
         end
         frame_tick = 1'b0; pause = 1'b0; spawn_ready = 1'b0;
         chk("rnd_spawns", sb_idx, n);
         chk("rnd_cnt", spawned_cnt, n);
         chk("rnd_done", queue_done, 1);
         chk("rnd_busy", busy, 0);
         cyc(2);
      end
      rnd = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
